// File: rtl/mul3_acc.sv
// mul3_acc: sums N unsigned 6-bit multiplier products per block. Both sides use valid/ready.
// Defining MUL3_ACC_SAT_EN saturates the accumulator; without it the accumulator wraps.
module mul3_acc #(
  parameter int N     = 4,
  parameter int ACC_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [5:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

`ifdef MUL3_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [7:0] LAST = 8'(N - 1);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc_nx;
  logic [7:0]       count, count_nx;
  logic             ovf_nx;
  logic [ACC_W:0]   sum;

  // Clamp to all-ones on carry-out when saturating; otherwise keep the low bits.
  function automatic logic [ACC_W-1:0] limit(input logic [ACC_W:0] s);
    limit = (SAT && s[ACC_W]) ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  assign sum        = {1'b0, acc} + {{(ACC_W-5){1'b0}}, prod};
  assign prod_ready = (state == S_ACC);
  assign acc_valid  = (state == S_HOLD);

  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    count_nx = count;
    ovf_nx   = ovf;
    if (clr) begin
      // A simultaneous product or hand-off is dropped; the stage starts fresh.
      state_nx = S_ACC;
      acc_nx   = '0;
      count_nx = '0;
      ovf_nx   = 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (prod_valid) begin
            acc_nx = limit(sum);
            ovf_nx = ovf | sum[ACC_W];
            if (count == LAST) begin
              state_nx = S_HOLD;
              count_nx = '0;
            end else begin
              count_nx = count + 8'd1;
            end
          end
        end
        S_HOLD: begin
          if (acc_ready) begin
            state_nx = S_ACC;
            acc_nx   = '0;
            ovf_nx   = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ACC;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      count <= count_nx;
      ovf   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_mul3_acc.sv
// tb_mul3_acc: four mul3_acc instances (N/ACC_W = 4/9, 5/8, 3/9, 1/9) driven one lane at a time;
// a block-level reference model queues expected totals and a monitor checks every presented result.
module tb_mul3_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] clr, prod_valid, acc_ready;
  logic [3:0] prod_ready, ovf, acc_valid;
  logic [5:0] prod [4];
  logic [8:0] acc_a, acc_c, acc_d;
  logic [7:0] acc_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int lane;
    int acc;
    int ovf;
  } exp_t;
  exp_t sb[$];

  int m_sum [4];
  int m_cnt [4];
  bit m_hold[4];

  always #5 clk = ~clk;

  mul3_acc #(.N(4), .ACC_W(9)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .prod(prod[0]), .prod_valid(prod_valid[0]),
    .prod_ready(prod_ready[0]), .acc(acc_a), .ovf(ovf[0]), .acc_valid(acc_valid[0]),
    .acc_ready(acc_ready[0]));
  mul3_acc #(.N(5), .ACC_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .prod(prod[1]), .prod_valid(prod_valid[1]),
    .prod_ready(prod_ready[1]), .acc(acc_b), .ovf(ovf[1]), .acc_valid(acc_valid[1]),
    .acc_ready(acc_ready[1]));
  mul3_acc #(.N(3), .ACC_W(9)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .prod(prod[2]), .prod_valid(prod_valid[2]),
    .prod_ready(prod_ready[2]), .acc(acc_c), .ovf(ovf[2]), .acc_valid(acc_valid[2]),
    .acc_ready(acc_ready[2]));
  mul3_acc #(.N(1), .ACC_W(9)) u_d (
    .clk(clk), .rst_n(rst_n), .clr(clr[3]), .prod(prod[3]), .prod_valid(prod_valid[3]),
    .prod_ready(prod_ready[3]), .acc(acc_d), .ovf(ovf[3]), .acc_valid(acc_valid[3]),
    .acc_ready(acc_ready[3]));

  function automatic int n_of(input int l);
    case (l)
      0:       return 4;
      1:       return 5;
      2:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int get_acc(input int l);
    case (l)
      0:       return int'(acc_a);
      1:       return int'(acc_b);
      2:       return int'(acc_c);
      default: return int'(acc_d);
    endcase
  endfunction

  // Expected block result from the plain sum of the block's products.
  function automatic exp_t block_result(input int l, input int total);
    exp_t e;
    int   mx;
    mx     = (1 << ((l == 1) ? 8 : 9)) - 1;
    e.lane = l;
    e.ovf  = (total > mx) ? 1 : 0;
`ifdef MUL3_ACC_SAT_EN
    e.acc  = (total > mx) ? mx : total;
`else
    e.acc  = total % (mx + 1);
`endif
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: decides acceptance from its own notion of block state.
  always @(negedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (!rst_n) begin
        m_hold[l] = 1'b0;
        m_sum[l]  = 0;
        m_cnt[l]  = 0;
      end
      chk("prod_ready", int'(prod_ready[l]), m_hold[l] ? 0 : 1);
      chk("acc_valid", int'(acc_valid[l]), m_hold[l] ? 1 : 0);
      if (rst_n) begin
        if (clr[l]) begin
          m_hold[l] = 1'b0;
          m_sum[l]  = 0;
          m_cnt[l]  = 0;
        end else if (m_hold[l]) begin
          if (acc_ready[l]) m_hold[l] = 1'b0;
        end else if (prod_valid[l]) begin
          m_sum[l] += int'(prod[l]);
          m_cnt[l] += 1;
          if (m_cnt[l] == n_of(l)) begin
            sb.push_back(block_result(l, m_sum[l]));
            m_hold[l] = 1'b1;
            m_sum[l]  = 0;
            m_cnt[l]  = 0;
          end
        end
      end
    end
    if (!rst_n) sb.delete();
  end

  // Monitor: every cycle a result is presented it must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < 4; l++) begin
        if (acc_valid[l]) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", l, -1);
          end else begin
            chk("out_lane", l, sb[0].lane);
            chk("out_acc", get_acc(l), sb[0].acc);
            chk("out_ovf", int'(ovf[l]), sb[0].ovf);
            if (acc_ready[l]) void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int l, input int p, input int gap, input bit rnd);
    bit done;
    done = 1'b0;
    idle(gap);
    prod[l]       = 6'(p);
    prod_valid[l] = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (prod_ready[l]) begin
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        if (rnd) acc_ready[l] = ($urandom_range(0, 2) != 0);
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    prod_valid[l] = 1'b0;
    if (rnd) acc_ready[l] = ($urandom_range(0, 2) != 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ln;
    clr        = '0;
    prod_valid = '0;
    acc_ready  = '1;
    for (int l = 0; l < 4; l++) prod[l] = '0;
    rst_n = 1'b0;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic block: 4 x 63 back-to-back.
    repeat (4) send(0, 63, 0, 1'b0);
    idle(3);

    // Overflow block then a clean block on the N=5, 8-bit lane.
    repeat (5) send(1, 63, 0, 1'b0);
    for (int p = 1; p <= 5; p++) send(1, p, 0, 1'b0);
    idle(3);

    // Back-pressure with gaps on the N=3 lane.
    acc_ready[2] = 1'b0;
    send(2, 7, $urandom_range(0, 3), 1'b0);
    send(2, 0, $urandom_range(0, 3), 1'b0);
    send(2, 49, $urandom_range(0, 3), 1'b0);
    idle(10);
    acc_ready[2] = 1'b1;
    idle(3);

    // Abort with a simultaneous product that must be discarded.
    send(0, 10, 0, 1'b0);
    send(0, 20, 0, 1'b0);
    prod[0]       = 6'd30;
    prod_valid[0] = 1'b1;
    clr[0]        = 1'b1;
    @(posedge clk);
    #1;
    clr[0]        = 1'b0;
    prod_valid[0] = 1'b0;
    chk("abort_acc", int'(acc_a), 0);
    chk("abort_ovf", int'(ovf[0]), 0);
    chk("abort_ready", int'(prod_ready[0]), 1);
    repeat (4) send(0, 1, 0, 1'b0);
    idle(3);

    // N=1 stream with prod_valid held high.
    send(3, 5, 0, 1'b0);
    send(3, 9, 0, 1'b0);
    send(3, 12, 0, 1'b0);
    idle(3);

    // Random blocks with random gaps and random back-pressure.
    for (int b = 0; b < 40; b++) begin
      ln = int'($urandom_range(0, 3));
      repeat (n_of(ln)) send(ln, int'($urandom_range(0, 63)), int'($urandom_range(0, 2)), 1'b1);
      acc_ready[ln] = 1'b1;
      idle(3);
    end

    // Asynchronous reset mid-block, mid-cycle, with prod_valid high.
    send(0, 3, 0, 1'b0);
    send(0, 4, 0, 1'b0);
    prod[0]       = 6'd5;
    prod_valid[0] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_acc", int'(acc_a), 0);
    chk("reset_ovf", int'(ovf[0]), 0);
    chk("reset_acc_valid", int'(acc_valid[0]), 0);
    chk("reset_prod_ready", int'(prod_ready[0]), 1);
    @(posedge clk);
    #1;
    prod_valid[0] = 1'b0;
    rst_n         = 1'b1;
    repeat (4) send(0, 2, 0, 1'b0);
    idle(3);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
